// File: rtl/fib_serial_sequencer_if.sv
// Purpose : start/result handshake bundle for the bit-serial Fibonacci
//           sequencer.
// Signals : start    - request a computation (sampled only while idle)
//           n        - Fibonacci index, sampled with start
//           busy     - run in progress
//           done     - one-cycle pulse, result/overflow valid from here
//           result   - F(n) mod 2^WIDTH, held until the next done
//           overflow - F(n) did not fit in WIDTH bits, held with result
// Modports: master drives start/n, slave (the sequencer) drives the rest.
interface fib_serial_sequencer_if #(
  parameter int WIDTH = 64,
  parameter int N_W   = 7
);
  logic             start;
  logic [N_W-1:0]   n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (output start, n, input busy, done, result, overflow);
  modport slave  (input start, n, output busy, done, result, overflow);
endinterface

// File: rtl/fib_serial_sequencer.sv
// Purpose : computes F(n) with a single one-bit full adder, spending WIDTH
//           clock cycles per addition. Operands rotate through the adder
//           LSB first; the sum is collected MSB-in in a shift register.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous, active-high
//           bus   - slave side of fib_serial_sequencer_if
//                   (start, n in; busy, done, result, overflow out)

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_a ^ i_b ^ i_cin;
  assign o_carry = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// state | meaning
// IDLE  | waiting for start; result/overflow hold the last run
// ADD   | one bit of a+b per cycle, LSB first, WIDTH cycles
// STEP  | shift the Fibonacci pair, update overflow, count iteration
// DONE  | single-cycle done pulse
module fib_serial_sequencer #(
  parameter int WIDTH = 64,
  parameter int N_W   = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  fib_serial_sequencer_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_STEP, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic [BW-1:0]    r_bitcnt;
  logic [N_W-1:0]   r_k;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;

  logic w_sum;
  logic w_carry;

  full_adder u_fa (
    .i_a     (r_a[0]),
    .i_b     (r_b[0]),
    .i_cin   (r_carry),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.overflow = r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_s        <= '0;
      r_carry    <= 1'b0;
      r_bitcnt   <= '0;
      r_k        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a        <= '0;
            r_b        <= WIDTH'(1);
            r_k        <= bus.n;
            r_carry    <= 1'b0;
            r_bitcnt   <= '0;
            r_overflow <= 1'b0;
            if (bus.n == '0) begin
              r_result <= '0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_ADD;
            end
          end
        end
        S_ADD: begin
          // a and b rotate so they are intact again after WIDTH cycles
          r_a      <= {r_a[0], r_a[WIDTH-1:1]};
          r_b      <= {r_b[0], r_b[WIDTH-1:1]};
          r_s      <= {w_sum, r_s[WIDTH-1:1]};
          r_carry  <= w_carry;
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_bitcnt == LAST_BIT) r_state <= S_STEP;
        end
        S_STEP: begin
          r_a      <= r_b;
          r_b      <= r_s;
          r_k      <= r_k - 1'b1;
          r_carry  <= 1'b0;
          r_bitcnt <= '0;
          // the last iteration builds F(n+1), whose carry-out is irrelevant
          if (r_k != N_W'(1) && r_carry) r_overflow <= 1'b1;
          if (r_k == N_W'(1)) begin
            r_result <= r_b;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_ADD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fib_serial_sequencer.sv
module tb_fib_serial_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fib_serial_sequencer_if #(.WIDTH(64), .N_W(7)) bus64 ();
  fib_serial_sequencer_if #(.WIDTH(8),  .N_W(7)) bus8 ();

  fib_serial_sequencer #(.WIDTH(64), .N_W(7)) u_dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus64)
  );

  fib_serial_sequencer #(.WIDTH(8), .N_W(7)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic s_done(input bit w8);
    return w8 ? bus8.done : bus64.done;
  endfunction

  function automatic logic s_busy(input bit w8);
    return w8 ? bus8.busy : bus64.busy;
  endfunction

  function automatic logic s_ovf(input bit w8);
    return w8 ? bus8.overflow : bus64.overflow;
  endfunction

  function automatic logic [63:0] s_result(input bit w8);
    return w8 ? 64'(bus8.result) : bus64.result;
  endfunction

  task automatic drive(input bit w8, input logic st, input int nn);
    if (w8) begin
      bus8.start = st;
      bus8.n     = 7'(nn);
    end else begin
      bus64.start = st;
      bus64.n     = 7'(nn);
    end
  endtask

  // lat counts rising edges from the accepting edge (inclusive) up to the
  // edge after which done is first seen high.
  task automatic run(input bit w8, input int nn, input int glitch_at, output int lat);
    int busy_bad;
    busy_bad = 0;
    @(negedge clk);
    drive(w8, 1'b1, nn);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      drive(w8, lat == glitch_at, (lat == glitch_at) ? 5 : nn);
      if (!s_done(w8) && !s_busy(w8)) busy_bad++;
      if (s_done(w8) && s_busy(w8)) busy_bad++;
    end while (!s_done(w8) && lat < 8000);
    check("busy_profile", busy_bad, 0);
    check("done_seen", s_done(w8), 1'b1);
  endtask

  initial begin
    int lat;
    int pulses;
    drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", bus64.busy, 1'b0);
    check("rst_done", bus64.done, 1'b0);
    check("rst_result", bus64.result, 64'd0);
    check("rst_ovf", bus64.overflow, 1'b0);

    // n = 0 and n = 1
    run(1'b0, 0, -1, lat);
    check("n0_lat", lat, 1);
    check("n0_result", bus64.result, 64'd0);
    run(1'b0, 1, -1, lat);
    check("n1_lat", lat, 66);
    check("n1_result", bus64.result, 64'd1);
    check("n1_ovf", bus64.overflow, 1'b0);
    @(negedge clk);
    check("n1_done_pulse", bus64.done, 1'b0);
    check("n1_result_held", bus64.result, 64'd1);

    // reset in the middle of an addition
    drive(1'b0, 1'b1, 10);
    @(negedge clk);
    drive(1'b0, 1'b0, 10);
    repeat (20) @(negedge clk);
    check("pre_rst_busy", bus64.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", bus64.busy, 1'b0);
    check("mid_rst_done", bus64.done, 1'b0);
    check("mid_rst_result", bus64.result, 64'd0);
    check("mid_rst_ovf", bus64.overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (700) begin
      @(negedge clk);
      if (bus64.done || bus64.busy) pulses++;
    end
    check("no_run_after_rst", pulses, 0);
    run(1'b0, 10, -1, lat);
    check("n10_result", bus64.result, 64'd55);
    check("n10_ovf", bus64.overflow, 1'b0);
    check("n10_lat", lat, 651);

    // largest F(n) that fits in 64 bits
    run(1'b0, 93, -1, lat);
    check("n93_result", bus64.result, 64'd12200160415121876738);
    check("n93_ovf", bus64.overflow, 1'b0);
    check("n93_lat", lat, 93 * 65 + 1);

    // 8-bit instance: boundary of representability
    run(1'b1, 13, -1, lat);
    check("w8_n13_result", s_result(1'b1), 64'd233);
    check("w8_n13_ovf", s_ovf(1'b1), 1'b0);
    check("w8_n13_lat", lat, 118);
    run(1'b1, 14, -1, lat);
    check("w8_n14_result", s_result(1'b1), 64'd121);
    check("w8_n14_ovf", s_ovf(1'b1), 1'b1);
    check("w8_n14_lat", lat, 127);

    // start pulsed with n=5 while busy on n=7 must be ignored
    run(1'b0, 7, 30, lat);
    check("glitch_result", bus64.result, 64'd13);
    check("glitch_lat", lat, 456);
    pulses = 0;
    repeat (600) begin
      @(negedge clk);
      if (bus64.done) pulses++;
    end
    check("glitch_single_done", pulses, 0);

    // back-to-back with start held high across DONE
    run(1'b1, 6, -1, lat);
    drive(1'b1, 1'b1, 3);
    check("b2b_first_result", s_result(1'b1), 64'd8);
    check("b2b_first_lat", lat, 55);
    @(negedge clk);
    check("b2b_idle_busy", s_busy(1'b1), 1'b0);
    check("b2b_idle_done", s_done(1'b1), 1'b0);
    check("b2b_idle_result", s_result(1'b1), 64'd8);
    @(negedge clk);
    drive(1'b1, 1'b0, 3);
    check("b2b_accept_busy", s_busy(1'b1), 1'b1);
    lat = 1;
    pulses = 0;
    while (!s_done(1'b1) && lat < 200) begin
      @(negedge clk);
      lat++;
      if (!s_done(1'b1) && !s_busy(1'b1)) pulses++;
    end
    check("b2b_busy_profile", pulses, 0);
    check("b2b_second_done", s_done(1'b1), 1'b1);
    check("b2b_second_result", s_result(1'b1), 64'd2);
    check("b2b_second_lat", lat, 28);
    check("b2b_second_ovf", s_ovf(1'b1), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
